// File: rtl/switch_event_scanner.sv
// switch_event_scanner
// Controlling end of the switch change-detector loop. Steps SCAN_COUNTER through
// the switches, feeds the committed SW_HISTORY back to the detector, commits each
// consistent change it reports and queues a {dir,idx} event in a small FWFT FIFO.
// When the FIFO is full, scanning freezes. Because history is not updated for a
// rejected change, the detector reports it again on a later pass.
// Optional build macro: SWITCH_SCAN_STATS_EN adds saturating Up/Down event counters.
module switch_event_scanner #(
  parameter int NUM_SW      = 10,
  parameter int FIFO_DEPTH  = 4,
  parameter int INIT_CYCLES = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_SW-1:0] SW_SYNC,
  input  logic [1:0]        SW_CHANGE_FLAG,
  input  logic [3:0]        WHICH_SW_CHANGE,
  output logic [3:0]        SCAN_COUNTER,
  output logic [NUM_SW-1:0] SW_HISTORY,
  output logic              EVT_VALID,
  output logic [4:0]        EVT_DATA,
  input  logic              EVT_READY,
  output logic [4:0]        EVT_COUNT,
  output logic              SCAN_STALL
`ifdef SWITCH_SCAN_STATS_EN
  ,
  output logic [7:0]        UP_EVT_CNT,
  output logic [7:0]        DOWN_EVT_CNT
`endif
);

  localparam int         PTR_W      = $clog2(FIFO_DEPTH);
  localparam int         BLANK_W    = $clog2(INIT_CYCLES + 1);
  localparam logic [4:0] DEPTH_C    = 5'(FIFO_DEPTH);
  localparam logic [3:0] NSW_C      = 4'(NUM_SW);
  localparam logic [3:0] LAST_IDX   = 4'(NUM_SW - 1);
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(INIT_CYCLES - 1);

  typedef enum logic [1:0] {ST_INIT, ST_SCAN, ST_STALL} state_t;

  state_t              state_q, state_d;
  logic [BLANK_W-1:0]  blank_q, blank_d;
  logic [3:0]          scan_q, scan_d;
  logic [NUM_SW-1:0]   history_q, history_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]          count_q, count_d;
  logic [4:0]          data_q, data_d;
  logic [4:0]          mem_q [FIFO_DEPTH];
  logic [4:0]          mem_d [FIFO_DEPTH];

  logic                full, push, pop;
  logic [15:0]         hist_ext, hist_upd;
  logic [4:0]          push_data;

  // Event acceptance and FIFO handshake, judged on start-of-cycle occupancy.
  always_comb begin
    full      = (count_q == DEPTH_C);
    hist_ext  = 16'(history_q);
    push_data = {SW_CHANGE_FLAG[1], WHICH_SW_CHANGE};
    push      = (state_q != ST_INIT) && SW_CHANGE_FLAG[0] &&
                (WHICH_SW_CHANGE < NSW_C) && !full &&
                (hist_ext[WHICH_SW_CHANGE] != SW_CHANGE_FLAG[1]);
    pop       = EVT_READY && (count_q != 5'd0);
  end

  // Scan FSM: blanking after reset, free-running scan, freeze while the FIFO is full.
  always_comb begin
    state_d = state_q;
    blank_d = blank_q;
    scan_d  = scan_q;
    unique case (state_q)
      ST_INIT: begin
        scan_d  = 4'd0;
        blank_d = blank_q + BLANK_W'(1);
        if (blank_q == BLANK_LAST) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        scan_d = (scan_q == LAST_IDX) ? 4'd0 : scan_q + 4'd1;
        if (full) state_d = ST_STALL;
      end
      ST_STALL: begin
        if (!full) state_d = ST_SCAN;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Committed history: tracks the raw switches while blanking, then accepted changes.
  always_comb begin
    hist_upd = hist_ext;
    if (push) hist_upd[WHICH_SW_CHANGE] = SW_CHANGE_FLAG[1];
    history_d = (state_q == ST_INIT) ? SW_SYNC : hist_upd[NUM_SW-1:0];
  end

  // FIFO pointers, occupancy and registered head (the pushed word if it lands at the head).
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = push_data;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + 5'(push) - 5'(pop);
    if (push && (count_q - 5'(pop) == 5'd0)) data_d = push_data;
    else if (count_d != 5'd0)                data_d = mem_q[rd_ptr_d];
    else                                     data_d = data_q;
  end

  // Control and history registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_INIT;
      blank_q   <= '0;
      scan_q    <= 4'd0;
      history_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= 5'd0;
      data_q    <= 5'd0;
    end else begin
      state_q   <= state_d;
      blank_q   <= blank_d;
      scan_q    <= scan_d;
      history_q <= history_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      data_q    <= data_d;
    end
  end

  // FIFO storage; contents are qualified by occupancy so it needs no reset.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign SCAN_COUNTER = scan_q;
  assign SW_HISTORY   = history_q;
  assign EVT_VALID    = (count_q != 5'd0);
  assign EVT_DATA     = data_q;
  assign EVT_COUNT    = count_q;
  assign SCAN_STALL   = (state_q == ST_STALL);

`ifdef SWITCH_SCAN_STATS_EN
  logic [7:0] up_q, up_d, dn_q, dn_d;

  // Saturating counts of accepted Up and Down events.
  always_comb begin
    up_d = up_q;
    dn_d = dn_q;
    if (push &&  SW_CHANGE_FLAG[1] && up_q != 8'hFF) up_d = up_q + 8'd1;
    if (push && !SW_CHANGE_FLAG[1] && dn_q != 8'hFF) dn_d = dn_q + 8'd1;
  end

  // Statistics registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      up_q <= 8'd0;
      dn_q <= 8'd0;
    end else begin
      up_q <= up_d;
      dn_q <= dn_d;
    end
  end

  assign UP_EVT_CNT   = up_q;
  assign DOWN_EVT_CNT = dn_q;
`endif

endmodule

// File: tb/tb_switch_event_scanner.sv
// Scoreboard bench for switch_event_scanner: a per-cycle reference model derived
// from the behavioural rules predicts history, scan index, stall and occupancy, and
// queues expected events; a monitor checks every handshaken EVT_DATA against the queue.
module tb_switch_event_scanner;
  localparam int NUM_SW = 10;
  localparam int DEPTH  = 4;
  localparam int INIT_C = 3;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic [NUM_SW-1:0] SW_SYNC = '0;
  logic [1:0]        SW_CHANGE_FLAG = 2'b00;
  logic [3:0]        WHICH_SW_CHANGE = 4'hF;
  logic [3:0]        SCAN_COUNTER;
  logic [NUM_SW-1:0] SW_HISTORY;
  logic              EVT_VALID;
  logic [4:0]        EVT_DATA;
  logic              EVT_READY = 1'b0;
  logic [4:0]        EVT_COUNT;
  logic              SCAN_STALL;
`ifdef SWITCH_SCAN_STATS_EN
  logic [7:0]        UP_EVT_CNT, DOWN_EVT_CNT;
`endif

  switch_event_scanner #(.NUM_SW(NUM_SW), .FIFO_DEPTH(DEPTH), .INIT_CYCLES(INIT_C)) dut (
    .CLK(CLK), .RESET(RESET), .SW_SYNC(SW_SYNC), .SW_CHANGE_FLAG(SW_CHANGE_FLAG),
    .WHICH_SW_CHANGE(WHICH_SW_CHANGE), .SCAN_COUNTER(SCAN_COUNTER), .SW_HISTORY(SW_HISTORY),
    .EVT_VALID(EVT_VALID), .EVT_DATA(EVT_DATA), .EVT_READY(EVT_READY),
    .EVT_COUNT(EVT_COUNT), .SCAN_STALL(SCAN_STALL)
`ifdef SWITCH_SCAN_STATS_EN
    , .UP_EVT_CNT(UP_EVT_CNT), .DOWN_EVT_CNT(DOWN_EVT_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [4:0] scb[$];

  // reference model state
  int                m_blank;
  bit                m_stall;
  int                m_scan;
  logic [NUM_SW-1:0] m_hist;
  int                m_cnt;
  int                m_up, m_dn;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("scan_counter", int'(SCAN_COUNTER), m_scan);
    chk("sw_history", int'(SW_HISTORY), int'(m_hist));
    chk("evt_count", int'(EVT_COUNT), m_cnt);
    chk("evt_valid", int'(EVT_VALID), (m_cnt > 0) ? 1 : 0);
    chk("scan_stall", int'(SCAN_STALL), int'(m_stall));
`ifdef SWITCH_SCAN_STATS_EN
    chk("up_evt_cnt", int'(UP_EVT_CNT), m_up);
    chk("down_evt_cnt", int'(DOWN_EVT_CNT), m_dn);
`endif
  endtask

  task automatic do_reset(input logic [NUM_SW-1:0] sw);
    RESET = 1'b1;
    SW_SYNC = sw;
    SW_CHANGE_FLAG = 2'b00;
    WHICH_SW_CHANGE = 4'hF;
    EVT_READY = 1'b0;
    scb.delete();
    m_blank = INIT_C; m_stall = 1'b0; m_scan = 0; m_hist = '0; m_cnt = 0;
    m_up = 0; m_dn = 0;
    #2;
    check_outputs();
    chk("reset_evt_data", int'(EVT_DATA), 0);
    @(posedge CLK); #1;
    RESET = 1'b0;
  endtask

  // One clock: check current outputs, apply inputs, advance the model, clock.
  task automatic step(input logic [NUM_SW-1:0] sw, input logic [1:0] fl,
                      input logic [3:0] wh, input logic rdy);
    bit full, acc, pop;
    check_outputs();
    SW_SYNC = sw; SW_CHANGE_FLAG = fl; WHICH_SW_CHANGE = wh; EVT_READY = rdy;
    pop = rdy && (m_cnt > 0);
    acc = 1'b0;
    if (m_blank > 0) begin
      m_hist = sw;
      m_scan = 0;
      m_blank--;
    end else begin
      full = (m_cnt == DEPTH);
      if (fl[0] && int'(wh) < NUM_SW && !full)
        if (m_hist[wh] != fl[1]) acc = 1'b1;
      if (acc) begin
        m_hist[wh] = fl[1];
        scb.push_back({fl[1], wh});
        if (fl[1]) m_up = (m_up < 255) ? m_up + 1 : 255;
        else       m_dn = (m_dn < 255) ? m_dn + 1 : 255;
      end
      if (!m_stall) m_scan = (m_scan + 1) % NUM_SW;
      m_stall = full;
    end
    m_cnt = m_cnt + int'(acc) - int'(pop);
    @(posedge CLK); #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(SW_SYNC, 2'b00, 4'hF, rdy);
  endtask

  // Monitor: every accepted handshake must deliver the oldest expected event.
  initial begin
    logic [4:0] exp;
    forever begin
      @(negedge CLK);
      if (!RESET && EVT_VALID && EVT_READY) begin
        if (scb.size() == 0) begin
          checks++; errors++;
          $display("FAIL evt_unexpected actual=%0h required=none", EVT_DATA);
        end else begin
          exp = scb.pop_front();
          chk("evt_data", int'(EVT_DATA), int'(exp));
        end
      end
    end
  end

  initial begin
    logic [1:0] fl;
    logic [3:0] wh;
    logic       rdy;
    int         rdy_bias;

    // blanking ignores the detector's reset-time Down codes
    do_reset(10'h005);
    for (int i = 0; i < INIT_C; i++) step(10'h005, 2'b01, 4'd0, 1'b0);
    step(10'h005, 2'b01, 4'd1, 1'b0);
    chk("init_history", int'(SW_HISTORY), 10'h005);
    chk("init_no_event", int'(EVT_COUNT), 0);

    // consistent Up on idx 3
    step(10'h005, 2'b11, 4'd3, 1'b0);
    chk("up3_data", int'(EVT_DATA), 5'h13);
    chk("up3_hist", int'(SW_HISTORY[3]), 1);
    // inconsistent Down on idx 5, out-of-range indices
    step(10'h005, 2'b01, 4'd5, 1'b0);
    step(10'h005, 2'b11, 4'hF, 1'b0);
    step(10'h005, 2'b11, 4'd12, 1'b0);
    idle(4, 1'b1);

    // backpressure: five Ups with no consumer, then drain and re-present idx 4
    do_reset('0);
    idle(INIT_C, 1'b0);
    for (int i = 0; i < 5; i++) step('0, 2'b11, 4'(i), 1'b0);
    idle(3, 1'b0);
    chk("stall_flag", int'(SCAN_STALL), 1);
    chk("stall_hist4", int'(SW_HISTORY[4]), 0);
    for (int i = 0; i < 4; i++) step('0, 2'b11, 4'd4, 1'b1);
    idle(6, 1'b1);

    // full FIFO, pop and valid event in the same cycle: push rejected
    do_reset('0);
    idle(INIT_C, 1'b0);
    for (int i = 0; i < 4; i++) step('0, 2'b11, 4'(i), 1'b0);
    step('0, 2'b11, 4'd5, 1'b1);
    chk("full_pop_count", int'(EVT_COUNT), 3);
    idle(14, 1'b1);

    // randomized traffic with occasional mid-operation reset
    rdy_bias = 5;
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) rdy_bias = $urandom_range(1, 9);
      if ($urandom_range(0, 599) == 0) begin
        do_reset(NUM_SW'($urandom));
        continue;
      end
      wh = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                       : 4'($urandom_range(0, NUM_SW - 1));
      fl[0] = ($urandom_range(0, 3) != 0);
      fl[1] = 1'($urandom_range(0, 1));
      if (int'(wh) < NUM_SW && $urandom_range(0, 9) < 6) fl[1] = ~m_hist[wh];
      rdy = ($urandom_range(0, 9) < rdy_bias);
      step(NUM_SW'($urandom), fl, wh, rdy);
    end
    idle(8, 1'b1);

`ifdef SWITCH_SCAN_STATS_EN
    do_reset('0);
    idle(INIT_C, 1'b1);
    for (int i = 0; i < 300; i++) begin
      step('0, 2'b11, 4'd0, 1'b1);
      step('0, 2'b01, 4'd0, 1'b1);
    end
    idle(4, 1'b1);
    chk("stats_up_sat", int'(UP_EVT_CNT), 255);
    chk("stats_dn_sat", int'(DOWN_EVT_CNT), 255);
`endif

    idle(2, 1'b1);
    chk("scb_drained", scb.size(), m_cnt);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
